// File: rtl/pipe_and_chain.sv
// pipe_and_chain: pipelined linear reduction of an N-bit vector with a
// per-item selectable operator (AND / OR / XOR; code 11 behaves as AND).
// One register stage per chain link, full valid/ready backpressure.
// Optional feature macro: PIPE_AND_CHAIN_TAPS_EN adds the out_taps port and
// carries every earlier partial result along so taps align with out_result.
module pipe_and_chain #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_bits,
  input  logic [1:0]   in_op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_result,
`ifdef PIPE_AND_CHAIN_TAPS_EN
  output logic [N-2:0] out_taps,
`endif
  output logic         out_valid,
  input  logic         out_ready
);

  // One chain link: combine running partial with the next operand bit.
  function automatic logic f_link(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b01:   f_link = a | b;
      2'b10:   f_link = a ^ b;
      default: f_link = a & b;
    endcase
  endfunction

  // Whole pipeline moves together; it only freezes when the head item is blocked.
  logic w_adv;
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  for (genvar s = 0; s < N - 1; s++) begin : g_st
    logic       r_vld;
    logic       r_part;
    logic       w_vld_in;
    logic [1:0] w_op_in;
    logic       w_a;
    logic       w_b;

    if (s == 0) begin : g_src
      assign w_vld_in = in_valid;
      assign w_op_in  = in_op;
      assign w_a      = in_bits[0];
      assign w_b      = in_bits[1];
    end else begin : g_src
      assign w_vld_in = g_st[s-1].r_vld;
      assign w_op_in  = g_st[s-1].g_opk.r_op;
      assign w_a      = g_st[s-1].r_part;
      assign w_b      = g_st[s-1].g_rem.r_rem[0];
    end

    // Stage valid and running partial; bubbles advance like real items.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_part <= 1'b0;
      end else if (w_adv) begin
        r_vld  <= w_vld_in;
        r_part <= f_link(w_op_in, w_a, w_b);
      end
    end

    // The op code and the not-yet-consumed operand bits are only needed
    // by later links, so the final stage does not keep them.
    if (s < N - 2) begin : g_opk
      logic [1:0] r_op;

      // Op code travels with its item so mixed-op streams stay correct.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_op <= 2'b00;
        else if (w_adv) r_op <= w_op_in;
      end
    end

    if (s < N - 2) begin : g_rem
      // r_rem[0] is in_bits[s+2], the operand consumed by the next link.
      logic [N-s-3:0] r_rem;
      logic [N-s-3:0] w_rem_in;

      if (s == 0) begin : g_rs
        assign w_rem_in = in_bits[N-1:2];
      end else begin : g_rs
        assign w_rem_in = g_st[s-1].g_rem.r_rem[N-s-2:1];
      end

      // Shift the remaining operands down one position per link.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_rem <= '0;
        else if (w_adv) r_rem <= w_rem_in;
      end
    end

`ifdef PIPE_AND_CHAIN_TAPS_EN
    if (s > 0) begin : g_tap
      // r_hist[k] is the partial over in_bits[0..k+1] of this item.
      logic [s-1:0] r_hist;
      logic [s-1:0] w_hist_in;

      if (s == 1) begin : g_hs
        assign w_hist_in = g_st[0].r_part;
      end else begin : g_hs
        assign w_hist_in = {g_st[s-1].r_part, g_st[s-1].g_tap.r_hist};
      end

      // Carry earlier partials forward so taps line up with the result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_hist <= '0;
        else if (w_adv) r_hist <= w_hist_in;
      end
    end
`endif
  end

  assign out_valid  = g_st[N-2].r_vld;
  assign out_result = g_st[N-2].r_part;

`ifdef PIPE_AND_CHAIN_TAPS_EN
  if (N > 2) begin : g_taps_out
    assign out_taps = {g_st[N-2].r_part, g_st[N-2].g_tap.r_hist};
  end else begin : g_taps_out
    assign out_taps = g_st[N-2].r_part;
  end
`endif

endmodule
